// File: rtl/tt_um_alvin_asmar_circuit_tester.sv
// ---------------------------------------------------------------------------
// tt_um_alvin_asmar_circuit_tester
//
// Stimulus/checker for the 3-input logic tile x = (A&B) | ~C, y = ~C.
// Drives the eight A/B/C vectors out on uio_out[2:0] and samples the
// returned x/y on uio_in[3]/uio_in[4]. After each vector has settled, the
// returned values are compared with the expected function and mismatches
// are counted. The count saturates at 15.
//
// Ports
//   clk      : single clock, rising edge
//   rst_n    : asynchronous active-low reset
//   ena      : always 1 when powered, unused
//   ui_in    : [0] start (synchronized, rising-edge detected)
//              [1] loop mode (synchronized)
//   uo_out   : [0] busy [1] done [2] pass [3] fail [7:4] mismatch count
//   uio_in   : [3] returned x, [4] returned y (synchronized)
//   uio_out  : [2:0] current vector {C,B,A}, [7:3] zero
//   uio_oe   : constant 8'h07
//
// State table
//   state    | meaning
//   IDLE     | after reset, waiting for a start edge
//   DRIVE    | vector register already holds the new vector; drive it
//   SETTLE   | wait SETTLE_CYCLES for the response through DUT + sync
//   SAMPLE   | compare synchronized x/y, then advance, wrap or finish
//   DONE     | hold results and last vector until the next start edge
// ---------------------------------------------------------------------------
module tt_um_alvin_asmar_circuit_tester #(
    parameter int unsigned SETTLE_CYCLES = 4   // legal range 3..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // The settle timer is a down-counter loaded on DRIVE -> SETTLE; the
    // SETTLE state lasts exactly SETTLE_CYCLES cycles when it reaches zero.
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    // Synchronizers
    logic r_start_s1, r_start_s2, r_start_d;
    logic r_loop_s1, r_loop_s2;
    logic r_x_s1, r_x_s2;
    logic r_y_s1, r_y_s2;

    // FSM and datapath registers
    state_t     r_state;
    logic [2:0] r_vec;
    logic [7:0] r_settle;
    logic [3:0] r_count;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic       r_fail;

    logic       w_start_rise;
    logic       w_exp_x;
    logic       w_exp_y;
    logic       w_miss;
    logic [3:0] w_count_next;
    logic       w_unused;

    assign w_unused = &{1'b0, ena, ui_in[7:2], uio_in[7:5], uio_in[2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_s1 <= 1'b0;
            r_start_s2 <= 1'b0;
            r_start_d  <= 1'b0;
            r_loop_s1  <= 1'b0;
            r_loop_s2  <= 1'b0;
            r_x_s1     <= 1'b0;
            r_x_s2     <= 1'b0;
            r_y_s1     <= 1'b0;
            r_y_s2     <= 1'b0;
        end else begin
            r_start_s1 <= ui_in[0];
            r_start_s2 <= r_start_s1;
            r_start_d  <= r_start_s2;
            r_loop_s1  <= ui_in[1];
            r_loop_s2  <= r_loop_s1;
            r_x_s1     <= uio_in[3];
            r_x_s2     <= r_x_s1;
            r_y_s1     <= uio_in[4];
            r_y_s2     <= r_y_s1;
        end
    end

    assign w_start_rise = r_start_s2 & ~r_start_d;

    assign w_exp_x = (r_vec[0] & r_vec[1]) | ~r_vec[2];
    assign w_exp_y = ~r_vec[2];

    // A vector with both outputs wrong still counts as a single mismatch.
    assign w_miss = (r_x_s2 != w_exp_x) | (r_y_s2 != w_exp_y);

    assign w_count_next = (w_miss && (r_count != 4'hF)) ? (r_count + 4'd1) : r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_vec    <= 3'd0;
            r_settle <= 8'd0;
            r_count  <= 4'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_fail   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_rise) begin
                        r_state <= S_DRIVE;
                        r_vec   <= 3'd0;
                        r_count <= 4'd0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_fail  <= 1'b0;
                    end
                end

                S_DRIVE: begin
                    r_state  <= S_SETTLE;
                    r_settle <= SETTLE_LOAD;
                end

                S_SETTLE: begin
                    if (r_settle == 8'd0) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_settle <= r_settle - 8'd1;
                    end
                end

                S_SAMPLE: begin
                    r_count <= w_count_next;
                    if (r_vec != 3'd7) begin
                        r_state <= S_DRIVE;
                        r_vec   <= r_vec + 3'd1;
                    end else if (r_loop_s2) begin
                        // Wrap for another sweep; the count keeps accumulating
                        // and pass/fail reflect everything seen so far.
                        r_state <= S_DRIVE;
                        r_vec   <= 3'd0;
                        r_pass  <= (w_count_next == 4'd0);
                        r_fail  <= (w_count_next != 4'd0);
                    end else begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_count_next == 4'd0);
                        r_fail  <= (w_count_next != 4'd0);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign uo_out  = {r_count, r_fail, r_pass, r_done, r_busy};
    assign uio_out = {5'b00000, r_vec};
    assign uio_oe  = 8'h07;

endmodule

// File: tb/tb_tt_um_alvin_asmar_circuit_tester.sv
module tb_tt_um_alvin_asmar_circuit_tester;

    localparam int SETTLE = 4;
    localparam int PER_VEC = SETTLE + 2;
    localparam int SWEEP = 8 * PER_VEC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    // Circuit-under-test behaviour: 0 correct, 1 x stuck-at-0, 2 x/y swapped,
    // 3 y stuck-at-1, 4 random per-vector corruption mask.
    int         mode = 0;
    logic [1:0] r_mask [8];

    tt_um_alvin_asmar_circuit_tester #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // Returns {y, x} as the board-side circuit would present them.
    function automatic logic [1:0] circuit_xy(input int m, input logic [2:0] v);
        logic a, b, c, gx, gy;
        a  = v[0];
        b  = v[1];
        c  = v[2];
        gx = (a & b) | ~c;
        gy = ~c;
        case (m)
            1:       return {gy, 1'b0};
            2:       return {gx, gy};
            3:       return {1'b1, gx};
            4:       return {gy ^ r_mask[v][1], gx ^ r_mask[v][0]};
            default: return {gy, gx};
        endcase
    endfunction

    // One-cycle-delayed response to the driven vector.
    always @(posedge clk) begin
        uio_in <= {3'b000, circuit_xy(mode, uio_out[2:0]), 3'b000};
    end

    // Expected mismatch count after a number of sweeps: x is 1 for vectors
    // 0..3 and 7, y is 1 for vectors 0..3.
    function automatic int model_count(input int sweeps);
        int cnt;
        logic [1:0] want;
        cnt = 0;
        for (int s = 0; s < sweeps; s++) begin
            for (int v = 0; v < 8; v++) begin
                want = {logic'(v < 4), logic'((v < 4) || (v == 7))};
                if (circuit_xy(mode, 3'(v)) != want) cnt++;
            end
        end
        return (cnt > 15) ? 15 : cnt;
    endfunction

    task automatic run_sweep(input string name, input int exp_count, input bit repulse);
        int n;
        bit vec_ok;
        @(negedge clk);
        ui_in[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (uo_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_early got %0b want 0", name, uo_out[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (uo_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_third_edge got %0b want 1", name, uo_out[0]);
        end
        ui_in[0] = 1'b0;
        n = 0;
        vec_ok = 1'b1;
        while (uo_out[0] === 1'b1 && n < 200) begin
            if (int'(uio_out[2:0]) != n / PER_VEC) vec_ok = 1'b0;
            if (repulse && n == 10) ui_in[0] = 1'b1;
            if (repulse && n == 14) ui_in[0] = 1'b0;
            if (repulse && n == 30) ui_in[0] = 1'b1;
            if (repulse && n == 33) ui_in[0] = 1'b0;
            n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (n != SWEEP) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d want %0d", name, n, SWEEP);
        end
        checks++;
        if (!vec_ok) begin
            errors++;
            $display("FAIL %s vector_steps got out-of-order vector want 0..7 each %0d cycles", name, PER_VEC);
        end
        checks++;
        if (uo_out !== {4'(exp_count), exp_count != 0, exp_count == 0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL %s results got %02h want count=%0d done=1 pass=%0d", name, uo_out,
                     exp_count, exp_count == 0);
        end
        checks++;
        if (uio_out !== 8'h07) begin
            errors++;
            $display("FAIL %s hold_vector got %02h want 07", name, uio_out);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h07) begin
            errors++;
            $display("FAIL reset_state got uo=%02h uio=%02h oe=%02h want 00 00 07", uo_out, uio_out, uio_oe);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h07) begin
            errors++;
            $display("FAIL idle_state got uo=%02h uio=%02h oe=%02h want 00 00 07", uo_out, uio_out, uio_oe);
        end
    endtask

    task automatic test_correct();
        mode = 0;
        run_sweep("correct", model_count(1), 1'b0);
    endtask

    task automatic test_x_stuck();
        mode = 1;
        run_sweep("x_stuck0", model_count(1), 1'b0);
    endtask

    task automatic test_swap();
        mode = 2;
        run_sweep("xy_swap", model_count(1), 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            for (int v = 0; v < 8; v++) r_mask[v] = 2'($urandom_range(0, 3));
            mode = 4;
            run_sweep($sformatf("random%0d", it), model_count(1), 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        mode = 0;
        @(negedge clk);
        ui_in[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ui_in[0] = 1'b0;
        n = 0;
        while (!(uo_out[0] === 1'b1 && uio_out[2:0] === 3'd4) && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL reset_mid_reach got timeout want vector 4");
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h07) begin
            errors++;
            $display("FAIL reset_mid got uo=%02h uio=%02h oe=%02h want 00 00 07", uo_out, uio_out, uio_oe);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_sweep("after_reset", model_count(1), 1'b0);
    endtask

    task automatic test_back_to_back();
        mode = 3;
        run_sweep("repulse", model_count(1), 1'b1);
    endtask

    task automatic test_loop();
        int exp;
        mode = 3;
        @(negedge clk);
        ui_in[1] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ui_in[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ui_in[0] = 1'b0;
        for (int k = 1; k <= 5 * SWEEP; k++) begin
            @(posedge clk);
            #1;
            if (k % SWEEP == 0 && k <= 4 * SWEEP) begin
                exp = model_count(k / SWEEP);
                checks++;
                if (uo_out !== {4'(exp), exp != 0, exp == 0, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL loop_sweep%0d got %02h want count=%0d busy=1 done=0", k / SWEEP, uo_out, exp);
                end
            end
            if (k == 4 * SWEEP + 8) ui_in[1] = 1'b0;
        end
        exp = model_count(5);
        checks++;
        if (uo_out !== {4'(exp), exp != 0, exp == 0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL loop_end got %02h want count=%0d done=1 busy=0", uo_out, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_correct();
        test_x_stuck();
        test_swap();
        test_random();
        test_reset_mid();
        test_back_to_back();
        test_loop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
